fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 52 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by the core top level.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN,
      ST_DEFER
   } fetch_state_t;

   // Fetch targets are word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_reg [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [1:0]       count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (flush) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
      end else begin
         // When full, the write slot is the head being popped in the same cycle.
         if (push) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head  = (count_reg != 2'd0) ? mem_reg[rd_ptr_reg] : '0;
   assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC ownership, redirect deferral across cache refills, buffer toward decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] icache_addr,
   input  logic [ILEN-1:0] icache_instr,
   input  logic            icache_stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_instr
);

   fetch_state_t    state_reg;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pend_pc_reg;
   logic [XLEN-1:0] redirect_target;
   logic            pend_valid;
   logic            buf_full;
   logic            push;
   logic            pop;
   logic [1:0]      buf_count;
   fetch_entry_t    wr_entry;
   fetch_entry_t    head;

   assign redirect_target = align_pc(redirect_pc);
   assign pend_valid      = (state_reg == ST_DEFER);
   assign buf_full        = (buf_count == 2'(BUF_DEPTH));

   assign pop  = id_valid && id_ready && !redirect_valid;
   assign push = !icache_stall && !redirect_valid && !pend_valid && (!buf_full || pop);
   assign wr_entry = '{pc: pc_reg, instr: icache_instr};

   // pc only moves on an unstalled cycle, so the refill address stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RUN;
         pc_reg      <= RESET_PC;
         pend_pc_reg <= '0;
      end else begin
         case (state_reg)
            ST_RUN: begin
               if (redirect_valid) begin
                  if (icache_stall) begin
                     pend_pc_reg <= redirect_target;
                     state_reg   <= ST_DEFER;
                  end else begin
                     pc_reg <= redirect_target;
                  end
               end else if (push) begin
                  pc_reg <= pc_reg + 32'd4;
               end
            end
            ST_DEFER: begin
               if (redirect_valid && icache_stall) begin
                  pend_pc_reg <= redirect_target;
               end else if (!icache_stall) begin
                  pc_reg    <= redirect_valid ? redirect_target : pend_pc_reg;
                  state_reg <= ST_RUN;
               end
            end
            default: state_reg <= ST_RUN;
         endcase
      end
   end

   fetch_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_fetch_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (redirect_valid),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (buf_count)
   );

   assign icache_addr = pc_reg;
   assign id_valid    = (buf_count != 2'd0);
   assign id_pc       = head.pc;
   assign id_instr    = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs. a queue model.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] icache_addr;
   logic [31:0] icache_instr;
   logic        icache_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] m_pend_pc;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .icache_addr    (icache_addr),
      .icache_instr   (icache_instr),
      .icache_stall   (icache_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_pend    = 1'b0;
      m_pend_pc = 32'h0;
   endtask

   // Transaction-level view: the buffer is a queue of at most two fetched words.
   task automatic model_step(input logic rv, input logic [31:0] rp, input logic st,
                             input logic rdy, input logic [31:0] instr);
      logic [31:0] tgt;
      tgt = rp & 32'hFFFF_FFFC;
      if (rv) begin
         m_q.delete();
         if (st) begin
            m_pend    = 1'b1;
            m_pend_pc = tgt;
         end else begin
            m_pc   = tgt;
            m_pend = 1'b0;
         end
      end else if (m_pend) begin
         if (!st) begin
            m_pc   = m_pend_pc;
            m_pend = 1'b0;
         end
      end else begin
         if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
         if (!st && m_q.size() < 2) begin
            m_q.push_back('{pc: m_pc, instr: instr});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare();
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      e_pc    = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
      e_instr = (m_q.size() > 0) ? m_q[0].instr : 32'h0;
      chk("icache_addr", icache_addr, m_pc);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() > 0});
      chk("id_pc", id_pc, e_pc);
      chk("id_instr", id_instr, e_instr);
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks the result.
   task automatic cycle(input logic rv, input logic [31:0] rp, input logic st, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rp;
      icache_stall   = st;
      id_ready       = rdy;
      icache_instr   = st ? 32'hDEAD_BEEF : (icache_addr ^ KEY);
      @(posedge clk);
      model_step(rv, rp, st, rdy, icache_instr);
      @(negedge clk);
      compare();
      $display("cyc rv=%0b rp=%h st=%0b rdy=%0b -> addr=%h v=%0b pc=%h instr=%h",
               rv, rp, st, rdy, icache_addr, id_valid, id_pc, id_instr);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      icache_stall   = 1'b0;
      icache_instr   = 32'h0;
      id_ready       = 1'b0;
      model_reset();
      #1;
      chk("rst_addr", icache_addr, 32'h0);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_instr", id_instr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int miss_left;
      logic        rv;
      logic [31:0] rp;

      // Reset then back-to-back hits.
      do_reset();
      cycle(0, 0, 0, 1);
      chk("hit0_pc", id_pc, 32'h0);
      chk("hit0_instr", id_instr, 32'hA5A5_0000);
      cycle(0, 0, 0, 1);
      chk("hit1_pc", id_pc, 32'h4);
      cycle(0, 0, 0, 1);
      chk("hit2_pc", id_pc, 32'h8);
      cycle(0, 0, 0, 1);
      chk("hit3_pc", id_pc, 32'hC);
      chk("hit3_instr", id_instr, 32'hA5A5_000C);

      // Backpressure: buffer fills with 0,4 and the address holds at 8.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      chk("bp_addr", icache_addr, 32'h8);
      chk("bp_head", id_pc, 32'h0);
      cycle(0, 0, 0, 1);
      chk("bp_rel0", id_pc, 32'h4);
      cycle(0, 0, 0, 1);
      chk("bp_rel1", id_pc, 32'h8);

      // Miss at 0x10: address held for the whole stall, word pushed afterwards.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 1, 1);
         chk("miss_addr", icache_addr, 32'h10);
      end
      chk("miss_empty", {31'b0, id_valid}, 32'h0);
      cycle(0, 0, 0, 1);
      chk("miss_push", id_pc, 32'h10);

      // Redirect on hit with a full buffer.
      do_reset();
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(1, 32'h203, 0, 1);
      chk("redir_flush", {31'b0, id_valid}, 32'h0);
      chk("redir_addr", icache_addr, 32'h200);
      cycle(0, 0, 0, 0);
      chk("redir_pc", id_pc, 32'h200);

      // Two redirects during a refill at 0x40.
      do_reset();
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 1);
      cycle(1, 32'h400, 1, 1);
      cycle(0, 0, 1, 1);
      cycle(1, 32'h500, 1, 1);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 1, 1);
      chk("defer_addr", icache_addr, 32'h40);
      cycle(0, 0, 0, 1);
      chk("defer_load", icache_addr, 32'h500);
      chk("defer_drop", {31'b0, id_valid}, 32'h0);
      cycle(0, 0, 0, 1);
      chk("defer_pc", id_pc, 32'h500);

      // PC wrap.
      cycle(1, 32'hFFFF_FFFE, 0, 1);
      cycle(0, 0, 0, 1);
      chk("wrap_addr", icache_addr, 32'h0);
      chk("wrap_pc", id_pc, 32'hFFFF_FFFC);

      // Asynchronous reset in the middle of a refill.
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      #2;
      rst_n        = 1'b0;
      icache_stall = 1'b0;
      #1;
      chk("arst_addr", icache_addr, 32'h0);
      chk("arst_valid", {31'b0, id_valid}, 32'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic.
      miss_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (miss_left == 0 && $urandom_range(0, 9) == 0) miss_left = 6 + $urandom_range(0, 3);
         rv = ($urandom_range(0, 11) == 0);
         rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 4095));
         cycle(rv, rp, miss_left > 0, $urandom_range(0, 3) != 0);
         if (miss_left > 0) miss_left--;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
